// File: rtl/spi_mnrch_if.sv
// Host-side request/response bundle of the SPI monarch: strobe and command in,
// completion flag and received word out.
interface spi_mnrch_if #(
    parameter int DATA_W = 16
);
    logic              wrt;
    logic [DATA_W-1:0] wt_data;
    logic              done;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wrt,
        output wt_data,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  wt_data,
        output done,
        output rd_data
    );
endinterface

// File: rtl/spi_mnrch.sv
// SPI monarch, mode 3: one DATA_W-bit full-duplex transfer per accepted wrt strobe.
// SCLK is the divider MSB, so both SCLK and MOSI come straight from flops.
module spi_mnrch #(
    parameter int DIV_W  = 5,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_mnrch_if.slave    bus,
    output logic          SS_n,
    output logic          SCLK,
    output logic          MOSI,
    input  logic          MISO
);

    localparam logic [DIV_W-1:0] FRONT_LD = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] ALL_ONES = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] MID_ONES = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]       LAST_BIT = 5'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FRONT = 2'b01,
        SHIFT = 2'b10,
        BACK  = 2'b11
    } state_t;

    state_t            state_r,     state_s;
    logic [DIV_W-1:0]  div_r,       div_s;
    logic [DATA_W-1:0] shft_r,      shft_s;
    logic              miso_smpl_r, miso_smpl_s;
    logic [4:0]        bit_cnt_r,   bit_cnt_s;
    logic              ss_n_r,      ss_n_s;
    logic              done_r,      done_s;
    logic [DIV_W-1:0]  div_inc_s;

    assign div_inc_s = div_r + DIV_ONE;

    // Next-state and next-register logic for the transfer sequencer
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        shft_s      = shft_r;
        miso_smpl_s = miso_smpl_r;
        bit_cnt_s   = bit_cnt_r;
        ss_n_s      = ss_n_r;
        done_s      = done_r;
        case (state_r)
            IDLE: begin
                // Accepting edge already counts as the first front-porch clock
                if (bus.wrt) begin
                    shft_s    = bus.wt_data;
                    bit_cnt_s = 5'd0;
                    done_s    = 1'b0;
                    ss_n_s    = 1'b0;
                    div_s     = FRONT_LD + DIV_ONE;
                    state_s   = FRONT;
                end else begin
                    div_s     = FRONT_LD;
                end
            end
            FRONT: begin
                if (div_r == ALL_ONES) begin
                    div_s   = {DIV_W{1'b0}};
                    state_s = SHIFT;
                end else begin
                    div_s   = div_inc_s;
                end
            end
            SHIFT: begin
                div_s = div_inc_s;
                if (div_r == MID_ONES) begin
                    miso_smpl_s = MISO;
                end else begin
                    miso_smpl_s = miso_smpl_r;
                end
                // Last shift parks the divider so SCLK never makes a trailing fall
                if (div_r == ALL_ONES) begin
                    shft_s    = {shft_r[DATA_W-2:0], miso_smpl_r};
                    bit_cnt_s = bit_cnt_r + 5'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        div_s   = ALL_ONES;
                        state_s = BACK;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    shft_s = shft_r;
                end
            end
            BACK: begin
                ss_n_s  = 1'b1;
                done_s  = 1'b1;
                div_s   = FRONT_LD;
                state_s = IDLE;
            end
            default: begin
                ss_n_s  = 1'b1;
                div_s   = FRONT_LD;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            div_r       <= FRONT_LD;
            shft_r      <= {DATA_W{1'b0}};
            miso_smpl_r <= 1'b0;
            bit_cnt_r   <= 5'd0;
            ss_n_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            shft_r      <= shft_s;
            miso_smpl_r <= miso_smpl_s;
            bit_cnt_r   <= bit_cnt_s;
            ss_n_r      <= ss_n_s;
            done_r      <= done_s;
        end
    end

    assign SS_n        = ss_n_r;
    assign SCLK        = div_r[DIV_W-1];
    assign MOSI        = shft_r[DATA_W-1];
    assign bus.done    = done_r;
    assign bus.rd_data = shft_r;

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch: loopback and sensor-model transfers, timing,
// ignored strobes, back-to-back requests and mid-transfer reset.
module tb_spi_mnrch;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        loop_en = 1'b1;
    logic [15:0] resp    = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    // Sensor-side observation, driven only by the monitor process
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          hi_viol  = 0;
    logic [15:0] cmd_cap  = 16'h0000;
    logic        sclk_prev = 1'b1;
    logic        ss_prev   = 1'b1;
    logic [3:0]  resp_idx;

    spi_mnrch_if #(.DATA_W(16)) bus ();

    spi_mnrch #(.DIV_W(5), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    assign resp_idx = 4'd15 - rise_cnt[3:0];
    assign MISO     = loop_en ? MOSI : resp[resp_idx];

    // Sensor model: counts SCLK edges, captures MOSI on rises, flags SCLK low while deselected
    always @(negedge clk) begin
        if (ss_prev && !SS_n) begin
            rise_cnt = 0;
            fall_cnt = 0;
            cmd_cap  = 16'h0000;
        end
        if (!SS_n && !sclk_prev && SCLK) begin
            rise_cnt = rise_cnt + 1;
            cmd_cap  = {cmd_cap[14:0], MOSI};
        end
        if (!SS_n && sclk_prev && !SCLK) begin
            fall_cnt = fall_cnt + 1;
        end
        if (SS_n && !SCLK) begin
            hi_viol = hi_viol + 1;
        end
        sclk_prev = SCLK;
        ss_prev   = SS_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a transfer at the next negedge; edge 0 is the clock that accepts wrt
    task automatic do_xfer(input logic [15:0] d, input int stray_at,
                           output int done_cyc, output int first_fall);
        done_cyc   = -1;
        first_fall = -1;
        @(negedge clk);
        bus.wrt     = 1'b1;
        bus.wt_data = d;
        @(posedge clk);
        #1;
        bus.wrt = 1'b0;
        check("ss_low_edge0", {31'd0, SS_n}, 32'd0);
        check("done_clr", {31'd0, bus.done}, 32'd0);
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (stray_at > 0 && k == stray_at - 1) begin
                bus.wrt     = 1'b1;
                bus.wt_data = 16'hFFFF;
            end
            if (stray_at > 0 && k == stray_at) begin
                bus.wrt = 1'b0;
            end
            if (first_fall < 0 && SCLK == 1'b0) first_fall = k;
            if (bus.done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int dc;
        int ff;
        bus.wrt     = 1'b0;
        bus.wt_data = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_sclk", {31'd0, SCLK}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rd", {16'd0, bus.rd_data}, 32'd0);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loopback 8F00 with full timing
        loop_en = 1'b1;
        do_xfer(16'h8F00, 0, dc, ff);
        check("lb_done_cyc", 32'(dc), 32'd521);
        check("lb_first_fall", 32'(ff), 32'd8);
        check("lb_rd", {16'd0, bus.rd_data}, 32'h8F00);
        check("lb_rises", 32'(rise_cnt), 32'd16);
        check("lb_falls", 32'(fall_cnt), 32'd16);
        check("lb_ss_hi", {31'd0, SS_n}, 32'd1);
        check("lb_sclk_hi", {31'd0, SCLK}, 32'd1);

        // Sensor answers 006A to command 8F00
        @(negedge clk);
        loop_en = 1'b0;
        resp    = 16'h006A;
        do_xfer(16'h8F00, 0, dc, ff);
        check("sen_done_cyc", 32'(dc), 32'd521);
        check("sen_cmd", {16'd0, cmd_cap}, 32'h8F00);
        check("sen_rd", {16'd0, bus.rd_data}, 32'h006A);

        // Stray wrt at edge 100 must be ignored
        @(negedge clk);
        loop_en = 1'b1;
        do_xfer(16'h1234, 100, dc, ff);
        check("stray_done_cyc", 32'(dc), 32'd521);
        check("stray_rd", {16'd0, bus.rd_data}, 32'h1234);
        check("stray_rises", 32'(rise_cnt), 32'd16);

        // Back-to-back: second wrt on the first clock after done
        do_xfer(16'hA5C3, 0, dc, ff);
        check("b2b1_done_cyc", 32'(dc), 32'd521);
        check("b2b1_rd", {16'd0, bus.rd_data}, 32'hA5C3);
        do_xfer(16'h3C5A, 0, dc, ff);
        check("b2b2_done_cyc", 32'(dc), 32'd521);
        check("b2b2_rd", {16'd0, bus.rd_data}, 32'h3C5A);

        // Asynchronous reset at edge 300 of a transfer
        @(negedge clk);
        bus.wrt     = 1'b1;
        bus.wt_data = 16'hC3C3;
        @(posedge clk);
        #1;
        bus.wrt = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, SS_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_ss_n", {31'd0, SS_n}, 32'd1);
        check("mid_sclk", {31'd0, SCLK}, 32'd1);
        check("mid_done", {31'd0, bus.done}, 32'd0);
        check("mid_rd", {16'd0, bus.rd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal transfer after reset release
        do_xfer(16'h0F0F, 0, dc, ff);
        check("post_done_cyc", 32'(dc), 32'd521);
        check("post_first_fall", 32'(ff), 32'd8);
        check("post_rd", {16'd0, bus.rd_data}, 32'h0F0F);
        check("post_rises", 32'(rise_cnt), 32'd16);

        repeat (4) @(posedge clk);
        #1;
        check("sclk_low_while_deselected", 32'(hi_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
